// File: rtl/package_settings.sv
// Board-level ADC settings shared by the channel processing blocks.
package package_settings;
  localparam int SIZE_ADC_DATA = 14;
endpackage

// File: rtl/trap_seq_pkg.sv
// Types and timing helpers for the trapezoidal-filter event sequencer.
package trap_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_ARMED   = 3'd2,
    S_CAPTURE = 3'd3,
    S_TAIL    = 3'd4,
    S_DRAIN   = 3'd5
  } seq_state_t;

  localparam int DEF_K        = 16;
  localparam int DEF_L        = 8;
  localparam int DEF_TAIL_MAX = 64;

  function automatic int settle_cyc(input int k, input int l);
    return k + l + 4;
  endfunction

  function automatic int cap_ofs(input int k, input int l);
    return k + l / 2;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_ONE;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/trap_event_sequencer.sv
// Per-channel pulse sequencer behind the trapezoidal filter: settle, trigger,
// flat-top capture, clean-tail commit and valid/ready readout of events.
module trap_event_sequencer
  import trap_seq_pkg::*;
#(
  parameter int DATA_W   = package_settings::SIZE_ADC_DATA * 2 + 3,
  parameter int K        = DEF_K,
  parameter int L        = DEF_L,
  parameter int TAIL_MAX = DEF_TAIL_MAX,
  parameter int TS_W     = 32,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] threshold,
  input  logic [DATA_W-1:0] filt_data,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [DATA_W-1:0] evt_amp,
  output logic [TS_W-1:0]   evt_time,
  output logic              busy,
  output logic [CNT_W-1:0]  short_cnt,
  output logic [CNT_W-1:0]  pileup_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int SETTLE_CYC = settle_cyc(K, L);
  localparam int CAP_OFS    = cap_ofs(K, L);
  localparam int PH_W       = $clog2(max3(SETTLE_CYC, CAP_OFS, TAIL_MAX) + 1);

  localparam logic [PH_W-1:0] PH_ONE      = PH_W'(1);
  localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYC - 1);
  localparam logic [PH_W-1:0] CAP_LAST    = PH_W'(CAP_OFS);
  localparam logic [PH_W-1:0] TAIL_LAST   = PH_W'(TAIL_MAX - 1);
  localparam logic [TS_W-1:0] TS_ONE      = TS_W'(1);

  seq_state_t        r_state;
  seq_state_t        w_state_run;
  seq_state_t        w_state_nxt;
  logic [PH_W-1:0]   r_ph_cnt;
  logic [PH_W-1:0]   w_ph_cnt_nxt;
  logic [TS_W-1:0]   r_ts;
  logic [TS_W-1:0]   r_pend_time;
  logic [DATA_W-1:0] r_pend_amp;
  logic              r_evt_valid;
  logic [DATA_W-1:0] r_evt_amp;
  logic [TS_W-1:0]   r_evt_time;
  logic              r_busy;

  logic w_above;
  logic w_latch_time;
  logic w_capture;
  logic w_commit;
  logic w_short_inc;
  logic w_pileup_inc;
  logic w_slot_free;
  logic w_load;
  logic w_drop;
  logic w_xfer;
  logic w_busy_nxt;

  assign w_above = $signed(filt_data) > $signed(threshold);

  // The settle, capture-offset and tail phases never overlap, so one counter serves all three.
  always_comb begin
    w_state_run  = r_state;
    w_ph_cnt_nxt = r_ph_cnt;
    w_latch_time = 1'b0;
    w_capture    = 1'b0;
    w_commit     = 1'b0;
    w_short_inc  = 1'b0;
    w_pileup_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_run  = S_SETTLE;
          w_ph_cnt_nxt = '0;
        end else begin
          w_state_run  = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (r_ph_cnt == SETTLE_LAST) begin
          w_state_run  = S_DRAIN;
        end else begin
          w_ph_cnt_nxt = r_ph_cnt + PH_ONE;
        end
      end
      S_DRAIN: begin
        if (!w_above) begin
          w_state_run = S_ARMED;
        end else begin
          w_state_run = S_DRAIN;
        end
      end
      S_ARMED: begin
        if (w_above) begin
          w_state_run  = S_CAPTURE;
          w_ph_cnt_nxt = PH_ONE;
          w_latch_time = 1'b1;
        end else begin
          w_state_run  = S_ARMED;
        end
      end
      S_CAPTURE: begin
        if (r_ph_cnt == CAP_LAST) begin
          w_state_run  = S_TAIL;
          w_ph_cnt_nxt = '0;
          w_capture    = 1'b1;
        end else if (!w_above) begin
          w_state_run  = S_ARMED;
          w_short_inc  = enable;
        end else begin
          w_ph_cnt_nxt = r_ph_cnt + PH_ONE;
        end
      end
      S_TAIL: begin
        // A clean return commits even when enable falls in the same cycle.
        if (!w_above) begin
          w_state_run  = S_ARMED;
          w_commit     = 1'b1;
        end else if (r_ph_cnt == TAIL_LAST) begin
          w_state_run  = S_DRAIN;
          w_pileup_inc = enable;
        end else begin
          w_ph_cnt_nxt = r_ph_cnt + PH_ONE;
        end
      end
      default: begin
        w_state_run = S_IDLE;
      end
    endcase
  end

  assign w_state_nxt = enable ? w_state_run : S_IDLE;
  assign w_busy_nxt  = !((w_state_nxt == S_IDLE) || (w_state_nxt == S_ARMED));

  assign w_xfer      = r_evt_valid & evt_ready;
  assign w_slot_free = ~r_evt_valid | evt_ready;
  assign w_load      = w_commit & w_slot_free;
  assign w_drop      = w_commit & ~w_slot_free;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ph_cnt <= '0;
      r_ts     <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ph_cnt <= w_ph_cnt_nxt;
      r_ts     <= r_ts + TS_ONE;
      r_busy   <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_time <= '0;
      r_pend_amp  <= '0;
    end else begin
      if (w_latch_time) begin
        r_pend_time <= r_ts;
      end
      if (w_capture) begin
        r_pend_amp <= filt_data;
      end
    end
  end

  // A commit landing on an accept cycle reloads the slot rather than clearing it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_evt_valid <= 1'b0;
      r_evt_amp   <= '0;
      r_evt_time  <= '0;
    end else if (w_load) begin
      r_evt_valid <= 1'b1;
      r_evt_amp   <= r_pend_amp;
      r_evt_time  <= r_pend_time;
    end else if (w_xfer) begin
      r_evt_valid <= 1'b0;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_short_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_short_inc),
    .count (short_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_pileup_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_pileup_inc),
    .count (pileup_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_drop),
    .count (drop_cnt)
  );

  assign evt_valid = r_evt_valid;
  assign evt_amp   = r_evt_amp;
  assign evt_time  = r_evt_time;
  assign busy      = r_busy;

endmodule

// File: tb/tb_trap_event_sequencer.sv
// Scoreboard bench: per-segment stimulus tables, an event-level reference model
// and a monitor that checks every cycle and every handshake transfer.
module tb_trap_event_sequencer;

  localparam int DW     = package_settings::SIZE_ADC_DATA * 2 + 3;
  localparam int NMAX   = 1024;
  localparam int SETTLE = 28;
  localparam int CAPO   = 20;
  localparam int TAILM  = 64;

  typedef struct packed {
    logic [DW-1:0] amp;
    logic [31:0]   tm;
  } ev_t;

  logic          clk;
  logic          reset;
  logic          enable;
  logic [DW-1:0] threshold;
  logic [DW-1:0] filt_data;
  logic          evt_valid;
  logic          evt_ready;
  logic [DW-1:0] evt_amp;
  logic [31:0]   evt_time;
  logic          busy;
  logic [15:0]   short_cnt;
  logic [15:0]   pileup_cnt;
  logic [15:0]   drop_cnt;

  trap_event_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .threshold  (threshold),
    .filt_data  (filt_data),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_amp    (evt_amp),
    .evt_time   (evt_time),
    .busy       (busy),
    .short_cnt  (short_cnt),
    .pileup_cnt (pileup_cnt),
    .drop_cnt   (drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  bit                   s_en  [NMAX];
  bit                   s_rdy [NMAX];
  logic signed [DW-1:0] s_thr [NMAX];
  logic signed [DW-1:0] s_fd  [NMAX];
  int                   n_cyc;

  bit            e_busy  [NMAX];
  bit            e_valid [NMAX];
  bit            m_commit[NMAX];
  logic [DW-1:0] m_amp   [NMAX];
  logic [31:0]   m_time  [NMAX];
  int            e_short, e_pile, e_drop;
  ev_t           exp_q[$];

  bit            d_busy  [NMAX];
  bit            d_valid [NMAX];
  logic [DW-1:0] last_amp;
  logic [31:0]   last_time;
  int            n_xfer;
  int            cur;
  bit            mon_on = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  function automatic bit above(input int c);
    return s_fd[c] > s_thr[c];
  endfunction

  task automatic clear_stim(input int n);
    n_cyc = n;
    for (int c = 0; c < NMAX; c++) begin
      s_en[c]  = 1'b1;
      s_rdy[c] = 1'b1;
      s_thr[c] = DW'(100);
      s_fd[c]  = '0;
    end
  endtask

  // Trapezoid: 16-sample rise, 8+ext flat top, 16-sample fall, on top of base.
  task automatic add_pulse(input int s, input int amp, input int ext, input int base);
    int flat;
    flat = 8 + ext;
    for (int o = 0; o < 16; o++)
      if (s + o < NMAX) s_fd[s + o] = DW'(base + amp * (o + 1) / 16);
    for (int o = 0; o < flat; o++)
      if (s + 16 + o < NMAX) s_fd[s + 16 + o] = DW'(base + amp);
    for (int o = 0; o < 16; o++)
      if (s + 16 + flat + o < NMAX) s_fd[s + 16 + flat + o] = DW'(base + amp * (15 - o) / 16);
  endtask

  // Walks the stimulus as the specified sequence of phases, then runs the output slot.
  task automatic run_model();
    int c, t0;
    bit alive, drain, cap, v;
    logic [DW-1:0] amp, sa;
    logic [31:0]   st;
    for (int i = 0; i < NMAX; i++) begin
      e_busy[i] = 1'b0; e_valid[i] = 1'b0; m_commit[i] = 1'b0;
    end
    e_short = 0; e_pile = 0; e_drop = 0;
    exp_q.delete();
    amp = '0; sa = '0; st = '0;
    c = 0;
    while (c < n_cyc) begin
      if (!s_en[c]) begin c++; continue; end
      c++;
      alive = 1'b1;
      for (int k = 0; k < SETTLE && alive && c < n_cyc; k++) begin
        e_busy[c] = 1'b1;
        if (!s_en[c]) alive = 1'b0;
        c++;
      end
      drain = 1'b1;
      while (alive && c < n_cyc) begin
        if (drain) e_busy[c] = 1'b1;
        if (!s_en[c]) begin alive = 1'b0; c++; end
        else if (drain) begin if (!above(c)) drain = 1'b0; c++; end
        else if (!above(c)) c++;
        else begin
          t0 = c; c++; cap = 1'b0;
          for (int j = 1; c < n_cyc; j++) begin
            e_busy[c] = 1'b1;
            if (!s_en[c]) begin alive = 1'b0; c++; break; end
            if (j == CAPO) begin amp = s_fd[c]; cap = 1'b1; c++; break; end
            if (!above(c)) begin e_short++; c++; break; end
            c++;
          end
          if (cap) begin
            for (int n = 0; c < n_cyc; n++) begin
              e_busy[c] = 1'b1;
              if (!above(c)) begin
                m_commit[c] = 1'b1; m_amp[c] = amp; m_time[c] = 32'(t0);
                if (!s_en[c]) alive = 1'b0;
                c++; break;
              end
              if (!s_en[c]) begin alive = 1'b0; c++; break; end
              if (n == TAILM - 1) begin e_pile++; drain = 1'b1; c++; break; end
              c++;
            end
          end
        end
      end
    end
    v = 1'b0;
    for (int k = 0; k < n_cyc; k++) begin
      e_valid[k] = v;
      if (v && s_rdy[k]) exp_q.push_back('{amp: sa, tm: st});
      if (m_commit[k]) begin
        if (!v || s_rdy[k]) begin v = 1'b1; sa = m_amp[k]; st = m_time[k]; end
        else e_drop++;
      end else if (v && s_rdy[k]) v = 1'b0;
    end
  endtask

  task automatic apply(input int c);
    enable    = s_en[c];
    evt_ready = s_rdy[c];
    threshold = s_thr[c];
    filt_data = s_fd[c];
  endtask

  task automatic run_segment();
    run_model();
    mon_on = 1'b0;
    reset = 1'b1; enable = 1'b0; evt_ready = 1'b0;
    threshold = '0; filt_data = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; n_xfer = 0; last_amp = '0; last_time = '0;
    cur = 0; apply(0); mon_on = 1'b1;
    @(negedge clk);
    check("rst_amp",    64'(evt_amp),    64'(0));
    check("rst_time",   64'(evt_time),   64'(0));
    check("rst_short",  64'(short_cnt),  64'(0));
    check("rst_pileup", 64'(pileup_cnt), 64'(0));
    check("rst_drop",   64'(drop_cnt),   64'(0));
    for (int c = 1; c < n_cyc; c++) begin
      @(posedge clk); #1;
      cur = c; apply(c);
    end
    @(posedge clk); #1;
    mon_on = 1'b0;
    check("short_cnt",  64'(short_cnt),  64'(e_short));
    check("pileup_cnt", 64'(pileup_cnt), 64'(e_pile));
    check("drop_cnt",   64'(drop_cnt),   64'(e_drop));
    check("pending_expected", 64'(exp_q.size()), 64'(0));
  endtask

  // Monitor: per-cycle valid/busy, and every transfer against the expected queue.
  initial begin
    ev_t ev;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        d_busy[cur]  = busy;
        d_valid[cur] = evt_valid;
        check("valid", 64'(evt_valid), 64'(e_valid[cur]));
        check("busy",  64'(busy),      64'(e_busy[cur]));
        if (evt_valid && evt_ready) begin
          n_xfer++;
          last_amp  = evt_amp;
          last_time = evt_time;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_event got=amp %0d time %0d exp=none", evt_amp, evt_time);
          end else begin
            ev = exp_q.pop_front();
            check("evt_amp",  64'(evt_amp),  64'(ev.amp));
            check("evt_time", 64'(evt_time), 64'(ev.tm));
          end
        end
      end
    end
  end

  task automatic gen_random(input int seg);
    int base, thr0, thr1, tchg, p, kind, amp, ext, len;
    clear_stim(700);
    base = (seg == 3) ? -600 : 0;
    thr0 = base + int'($urandom_range(60, 300));
    thr1 = base + int'($urandom_range(60, 300));
    tchg = int'($urandom_range(100, 600));
    for (int c = 0; c < n_cyc; c++) begin
      s_rdy[c] = ($urandom_range(0, 9) < 7);
      s_thr[c] = DW'((c < tchg) ? thr0 : thr1);
      s_fd[c]  = DW'(base + int'($urandom_range(0, 100)) - 50);
    end
    p = int'($urandom_range(40, 70));
    while (p < n_cyc - 160) begin
      kind = int'($urandom_range(0, 3));
      if (kind == 2) begin
        len = int'($urandom_range(1, 19));
        amp = int'($urandom_range(400, 1500));
        for (int i = 0; i < len; i++) s_fd[p + i] = DW'(base + amp);
        p += len;
      end else begin
        amp = int'($urandom_range(350, 2500));
        ext = (kind == 3) ? int'($urandom_range(60, 110)) : int'($urandom_range(0, 4));
        add_pulse(p, amp, ext, base);
        p += 40 + ext;
      end
      p += int'($urandom_range(5, 40));
    end
    if ($urandom_range(0, 1) == 1) begin
      p   = int'($urandom_range(100, 600));
      len = int'($urandom_range(1, 4));
      for (int i = 0; i < len; i++) s_en[p + i] = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; evt_ready = 1'b0; threshold = '0; filt_data = '0;

    // Held above threshold through settle: drain until the first zero sample.
    clear_stim(100);
    for (int c = 0; c < 70; c++) s_fd[c] = DW'(500);
    run_segment();
    check("s1_busy_idle",       64'(d_busy[0]),  64'(0));
    check("s1_busy_settle_1st", 64'(d_busy[1]),  64'(1));
    check("s1_busy_settle_end", 64'(d_busy[28]), 64'(1));
    check("s1_busy_drain",      64'(d_busy[70]), 64'(1));
    check("s1_armed",           64'(d_busy[71]), 64'(0));
    check("s1_events",          64'(n_xfer),     64'(0));

    // Clean trapezoid: crossing at cycle 41, commit at 78, one-cycle valid.
    clear_stim(120);
    add_pulse(40, 1000, 0, 0);
    run_segment();
    check("s2_events",  64'(n_xfer),      64'(1));
    check("s2_amp",     64'(last_amp),    64'(1000));
    check("s2_time",    64'(last_time),   64'(41));
    check("s2_valid_on",  64'(d_valid[79]), 64'(1));
    check("s2_valid_off", 64'(d_valid[80]), 64'(0));

    // Five-cycle pulse is rejected as short.
    clear_stim(80);
    for (int c = 40; c < 45; c++) s_fd[c] = DW'(500);
    run_segment();
    check("s3_short",  64'(short_cnt), 64'(1));
    check("s3_events", 64'(n_xfer),    64'(0));
    check("s3_armed",  64'(d_busy[46]), 64'(0));

    // Long flat top piles up; a later clean pulse still gets through.
    clear_stim(400);
    add_pulse(40, 1000, 100, 0);
    add_pulse(250, 1000, 0, 0);
    run_segment();
    check("s4_pileup", 64'(pileup_cnt), 64'(1));
    check("s4_events", 64'(n_xfer),     64'(1));
    check("s4_time",   64'(last_time),  64'(251));

    // Consumer stalled over two events: first held, second dropped.
    clear_stim(300);
    add_pulse(40, 1000, 0, 0);
    add_pulse(100, 700, 0, 0);
    for (int c = 0; c < 200; c++) s_rdy[c] = 1'b0;
    run_segment();
    check("s5_drop",   64'(drop_cnt),  64'(1));
    check("s5_events", 64'(n_xfer),    64'(1));
    check("s5_amp",    64'(last_amp),  64'(1000));
    check("s5_time",   64'(last_time), 64'(41));

    // Enable dropped mid-capture, then a full settle before re-arming.
    clear_stim(300);
    add_pulse(40, 1000, 0, 0);
    add_pulse(150, 1000, 0, 0);
    for (int c = 50; c < 55; c++) s_en[c] = 1'b0;
    run_segment();
    check("s6_idle",        64'(d_busy[51]), 64'(0));
    check("s6_settle_1st",  64'(d_busy[56]), 64'(1));
    check("s6_settle_end",  64'(d_busy[83]), 64'(1));
    check("s6_armed",       64'(d_busy[85]), 64'(0));
    check("s6_short",       64'(short_cnt),  64'(0));
    check("s6_events",      64'(n_xfer),     64'(1));
    check("s6_time",        64'(last_time),  64'(151));

    for (int seg = 0; seg < 6; seg++) begin
      gen_random(seg);
      run_segment();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
